// File: rtl/kms_serial_rx_if.sv
// Payload handshake bundle for the KMS serial receiver.
// master drives data/data_valid; slave returns data_ready.
interface kms_serial_rx_if #(
   parameter int DATA_W = 40
) ();
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic              data_ready;

   modport master (
      output data,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/kms_serial_rx.sv
// KMS link frame receiver: start, DATA_W payload bits, [parity], guard, stop.
// Optional odd-parity check is enabled by defining KMS_RX_PARITY_EN.
module kms_serial_rx #(
   parameter int DATA_W    = 40,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   kms_serial_rx_if.master  rx,
   output logic             overrun,
   output logic             stop_err,
   output logic             parity_err,
   output logic             link_reset,
   output logic             busy
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
`ifdef KMS_RX_PARITY_EN
      S_PAR,
`endif
      S_GUARD,
      S_STOP,
      S_LINKRST
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              all_ones_q, all_ones_d;
   logic              dv_q, dv_d;
   logic              ov_q, ov_d;
   logic              se_q, se_d;
   logic              lr_q, lr_d;
   logic              deliver;
`ifdef KMS_RX_PARITY_EN
   logic              par_ok_q, par_ok_d;
   logic              pe_q, pe_d;
`endif

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      shift_d    = shift_q;
      data_d     = data_q;
      all_ones_d = all_ones_q;
      dv_d       = dv_q & ~rx.data_ready;
      ov_d       = 1'b0;
      se_d       = 1'b0;
      lr_d       = lr_q;
      deliver    = 1'b0;
`ifdef KMS_RX_PARITY_EN
      par_ok_d   = par_ok_q;
      pe_d       = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (si) begin
               state_d    = S_DATA;
               count_d    = '0;
               all_ones_d = 1'b1;
            end
         end
         S_DATA: begin
            if (MSB_FIRST != 0) shift_d = {shift_q[DATA_W-2:0], si};
            else                shift_d = {si, shift_q[DATA_W-1:1]};
            all_ones_d = all_ones_q & si;
            count_d    = count_q + CW'(1);
            if (count_q == LAST) begin
`ifdef KMS_RX_PARITY_EN
               state_d = S_PAR;
`else
               state_d = S_GUARD;
`endif
            end
         end
`ifdef KMS_RX_PARITY_EN
         S_PAR: begin
            // odd parity: payload plus parity bit must hold an odd count of ones
            par_ok_d = ^{shift_q, si};
            state_d  = S_GUARD;
         end
`endif
         S_GUARD: begin
`ifdef KMS_RX_PARITY_EN
            deliver = par_ok_q;
            pe_d    = ~par_ok_q;
`else
            deliver = 1'b1;
`endif
            if (deliver) begin
               data_d = shift_q;
               dv_d   = 1'b1;
               ov_d   = dv_q & ~rx.data_ready;
            end
            state_d = S_STOP;
         end
         S_STOP: begin
            if (si && all_ones_q) begin
               state_d = S_LINKRST;
               lr_d    = 1'b1;
            end else begin
               se_d    = si;
               state_d = S_IDLE;
            end
         end
         S_LINKRST: begin
            if (!si) begin
               state_d = S_IDLE;
               lr_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         all_ones_q <= 1'b0;
         dv_q       <= 1'b0;
         ov_q       <= 1'b0;
         se_q       <= 1'b0;
         lr_q       <= 1'b0;
`ifdef KMS_RX_PARITY_EN
         par_ok_q   <= 1'b0;
         pe_q       <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         all_ones_q <= all_ones_d;
         dv_q       <= dv_d;
         ov_q       <= ov_d;
         se_q       <= se_d;
         lr_q       <= lr_d;
`ifdef KMS_RX_PARITY_EN
         par_ok_q   <= par_ok_d;
         pe_q       <= pe_d;
`endif
      end
   end

   assign rx.data       = data_q;
   assign rx.data_valid = dv_q;
   assign overrun       = ov_q;
   assign stop_err      = se_q;
   assign link_reset    = lr_q;
   assign busy          = (state_q != S_IDLE);
`ifdef KMS_RX_PARITY_EN
   assign parity_err    = pe_q;
`else
   assign parity_err    = 1'b0;
`endif

endmodule

// File: doc/kms_serial_rx.md
Name: kms_serial_rx

Overview:
- Parametrised successor to the NeXT keyboard/mouse/sound (KMS) serial frame receiver in the ossc_nextasic path.
- Deserialises one-bit-per-clock frames from the ASIC link into DATA_W-bit words.
- Delivers words on a valid/ready handshake with overrun reporting.
- Detects the all-ones link-reset frame, reports stop-bit errors and, optionally, checks parity.

Parameters:
- DATA_W, 40, payload bits per frame (2..64).
- MSB_FIRST, 1, 1: the first received bit lands in data[DATA_W-1]; 0: the first received bit lands in data[0].

Ports:
- clk  in  1  link bit clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- si  in  1  serial input; idle level 0.
- data  out  DATA_W  last delivered frame payload.
- data_valid  out  1  payload available; held until accepted.
- data_ready  in  1  consumer accepts data when data_valid and data_ready are both 1 at posedge.
- overrun  out  1  one-cycle pulse: a new frame replaced an unaccepted one.
- stop_err  out  1  one-cycle pulse: stop slot sampled 1 on a non-all-ones frame.
- parity_err  out  1  one-cycle pulse: parity mismatch (RX_PARITY_EN only; else constant 0).
- link_reset  out  1  level: all-ones reset frame seen; held until si returns to 0.
- busy  out  1  1 in any state except IDLE.

Behaviour:
- Reset: state=IDLE; bit counter=0; shift register=0; data=0. All other outputs (data_valid, overrun, stop_err, parity_err, link_reset, busy) = 0.
- Reset mid-frame: the frame is dropped and nothing is delivered.
- Frame on si (one bit per clk):
  - start bit (1);
  - DATA_W payload bits;
  - PAR slot (RX_PARITY_EN only);
  - GUARD slot (ignored);
  - STOP slot (expected 0).
  - Frame length = DATA_W+3 cycles (+1 with parity).
- States:
  - IDLE: si=1 → DATA; count=0; all_ones=1.
  - DATA: shift si into the shift register per MSB_FIRST; all_ones &= si; count++. When count==DATA_W-1 on this edge → PAR if enabled, else GUARD.
  - PAR: compare si with the parity bit; record the result → GUARD.
  - GUARD: on this edge, deliver the frame if parity is ok or disabled → STOP.
    - Delivery: data<=shift register; data_valid<=1.
    - If data_valid was already 1 and not accepted on the same edge: overrun pulses 1 and the new data overwrites the old.
  - STOP:
    - si=1 and all_ones → LINKRST; link_reset<=1.
    - si=1 and not all_ones → stop_err pulse → IDLE.
    - si=0 → IDLE.
  - LINKRST: link_reset stays 1; si=0 → IDLE; link_reset clears on the same edge.
- The all-ones frame is still delivered on data (data = all ones, data_valid = 1) before link_reset rises.
- Handshake: data_valid clears on the edge where data_valid and data_ready are both 1.
  - If delivery and acceptance coincide on one edge, the new word wins: data_valid stays 1, no overrun.
  - data is stable while data_valid=1, except on overwrite.
- Back-to-back frames: IDLE may see the next start bit on the cycle immediately after STOP. Minimum frame period = DATA_W+3 cycles.
- busy=1 in DATA, PAR, GUARD, STOP and LINKRST.
- The counter is $clog2(DATA_W+1) bits wide; it never wraps within a frame.

Optional Feature:
- Macro: KMS_RX_PARITY_EN.
- Defined:
  - The PAR slot follows the payload; odd parity over the payload plus the parity bit.
  - On mismatch: parity_err pulses during STOP; the frame is not delivered (no data_valid, no overrun); link-reset detection still uses all_ones.
- Undefined:
  - No PAR state; frame length is DATA_W+3; parity_err is tied 0.

Test Plan:
- DATA_W=40, MSB_FIRST=1. Send start, payload 40'hA5_0123_4567, guard 0, stop 0, with data_ready=1 → data=40'hA501234567; data_valid high for exactly 1 cycle; stop_err=0; link_reset=0.
- Two back-to-back frames 40'h1 then 40'h2 with data_ready=0 → after the second frame: data=40'h2, data_valid=1, one overrun pulse. Raise data_ready → data_valid clears on the next edge.
- All-ones payload with stop slot 1, then si held 1 for 10 cycles, then 0 → data=40'hFF_FFFF_FFFF delivered. link_reset rises at the STOP edge, stays 1 through the hold, and clears on the first edge with si=0. busy=0 the next cycle.
- Payload 40'h0F with stop slot 1 → data delivered; stop_err pulses once; state returns to IDLE; link_reset stays 0.
- Assert rst in cycle 20 of a frame → all outputs 0 the next cycle, no delivery. A subsequent clean frame 40'h55 is received correctly.
- With KMS_RX_PARITY_EN, DATA_W=8:
  - payload 8'h03 with parity bit 1 → delivered;
  - same payload with parity bit 0 → parity_err pulse, data_valid stays 0.
